// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side family: packer state encodings
// and default geometry constants.
package fifo_rd_packer_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RATIO      = 4;

endpackage

// File: rtl/fifo_rd_packer.sv
// Packs RATIO consecutive FIFO read words into one wide output beat; a flush
// closes a partial beat early and marks it with out_last.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RATIO      = DEF_RATIO
) (
  input  logic                        rd_clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                        fifo_rd_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last
);

  localparam int CW = $clog2(RATIO + 1);

  state_t                      r_state;
  logic [CW-1:0]               r_acc_cnt;
  logic                        r_pop_d;
  logic                        r_out_valid;
  logic [DATA_WIDTH*RATIO-1:0] r_out_data;
  logic [RATIO-1:0]            r_out_keep;
  logic                        r_out_last;

  logic [CW-1:0]               w_fill;
  logic                        w_slot_free;
  logic                        w_full;
  logic                        w_close;
  logic                        w_xfer;
  logic                        w_pop;
  logic [DATA_WIDTH*RATIO-1:0] w_beat;
  logic [RATIO-1:0]            w_keep;

  // w_fill counts the word landing this cycle, so a beat can close on the
  // same edge its last word arrives and pops never bubble between beats.
  assign w_fill      = r_acc_cnt + {{(CW-1){1'b0}}, r_pop_d};
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_full      = (w_fill == CW'(RATIO));
  assign w_close     = (r_state == ST_FLUSH) && !r_pop_d && (r_acc_cnt != '0);
  assign w_xfer      = w_slot_free && (w_full || w_close);
  assign fifo_rd_en  = !fifo_empty && !rst && (r_state == ST_ACCUM) &&
                       ((w_fill < CW'(RATIO)) || w_xfer);
  assign w_pop       = fifo_rd_en && !fifo_empty;

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge rd_clk) begin
      if (r_pop_d && (r_acc_cnt == CW'(g)))
        r_q <= fifo_rd_data;
    end

    assign w_beat[g*DATA_WIDTH +: DATA_WIDTH] =
      (CW'(g) < r_acc_cnt)                  ? r_q :
      (r_pop_d && (r_acc_cnt == CW'(g)))    ? fifo_rd_data : '0;
    assign w_keep[g] = (CW'(g) < w_fill);
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc_cnt   <= '0;
      r_pop_d     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_pop_d   <= w_pop;
      r_acc_cnt <= w_xfer ? '0 : w_fill;

      case (r_state)
        ST_ACCUM: if (flush) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_xfer || (!r_pop_d && (r_acc_cnt == '0))) r_state <= ST_ACCUM;
        default:  r_state <= ST_ACCUM;
      endcase

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat;
        r_out_keep  <= w_keep;
        r_out_last  <= (r_state == ST_FLUSH);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DATA_WIDTH=8, RATIO=4) with a
// behavioural registered-output FIFO feeding the read side.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int R  = 4;

  logic          rd_clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW*R-1:0] out_data;
  logic [R-1:0]  out_keep;
  logic          out_last;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [64];
  int wptr = 0, rptr = 0, cyc = 0;
  int pops = 0, run_len = 0, max_run = 0;

  logic [31:0] bd [$];
  logic [3:0]  bk [$];
  logic        bl [$];
  int          bc [$];

  fifo_rd_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wptr % 64] = w;
    wptr++;
    fifo_empty = 1'b0;
  endtask

  // Sample at the falling edge, then model the FIFO's registered read port.
  task automatic step();
    bit pop_now;
    @(negedge rd_clk);
    if (out_valid && out_ready) begin
      bd.push_back(out_data);
      bk.push_back(out_keep);
      bl.push_back(out_last);
      bc.push_back(cyc);
    end
    pop_now = fifo_rd_en && !fifo_empty;
    if (pop_now) begin
      pops++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    @(posedge rd_clk);
    cyc++;
    #1;
    if (pop_now) begin
      fifo_rd_data = mem[rptr % 64];
      rptr++;
      fifo_empty = (rptr == wptr);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear();
    bd.delete(); bk.delete(); bl.delete(); bc.delete();
    pops = 0; run_len = 0; max_run = 0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    fifo_empty = 1'b1; fifo_rd_data = '0;

    // Reset, with words already waiting in the FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data",  out_data, 32'h0);
    check("rst_keep",  out_keep, 4'h0);
    check("rst_last",  out_last, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);

    // Four words -> one full beat
    rst = 1'b0; clear();
    run(10);
    check("full_beats", bd.size(), 1);
    check("full_data",  bd[0], 32'h44332211);
    check("full_keep",  bk[0], 4'hF);
    check("full_last",  bl[0], 1'b0);
    check("full_drop",  out_valid, 1'b0);

    // Eight words -> back-to-back pops, beats four cycles apart
    clear();
    for (int i = 1; i <= 8; i++) push(8'(i));
    run(14);
    check("tp_run",   max_run, 8);
    check("tp_pops",  pops, 8);
    check("tp_beats", bd.size(), 2);
    check("tp_data0", bd[0], 32'h04030201);
    check("tp_data1", bd[1], 32'h08070605);
    check("tp_gap",   bc[1] - bc[0], 4);

    // Three words stall on empty, then a flush closes the partial beat
    clear();
    push(8'hA1); push(8'hA2); push(8'hA3);
    run(6);
    check("stall_beats", bd.size(), 0);
    check("stall_valid", out_valid, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    run(6);
    check("fl_beats", bd.size(), 1);
    check("fl_data",  bd[0], 32'h00A3A2A1);
    check("fl_keep",  bk[0], 4'h7);
    check("fl_last",  bl[0], 1'b1);

    // Backpressure: twelve words, only eight popped while blocked
    clear();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
    run(14);
    check("bp_pops",   pops, 8);
    check("bp_rd_en",  fifo_rd_en, 1'b0);
    check("bp_valid",  out_valid, 1'b1);
    check("bp_data",   out_data, 32'h24232221);
    check("bp_keep",   out_keep, 4'hF);
    run(3);
    check("bp_hold_data", out_data, 32'h24232221);
    check("bp_hold_last", out_last, 1'b0);
    check("bp_hold_pops", pops, 8);
    out_ready = 1'b1;
    run(14);
    check("bp_beats", bd.size(), 3);
    check("bp_d0", bd[0], 32'h24232221);
    check("bp_d1", bd[1], 32'h28272625);
    check("bp_d2", bd[2], 32'h2C2B2A29);
    check("bp_total_pops", pops, 12);

    // Flush with nothing accumulated emits nothing; packing resumes
    clear();
    flush = 1'b1; step(); flush = 1'b0;
    run(4);
    check("ef_beats", bd.size(), 0);
    check("ef_valid", out_valid, 1'b0);
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    run(8);
    check("ef_next_beats", bd.size(), 1);
    check("ef_next_data",  bd[0], 32'h34333231);
    check("ef_next_last",  bl[0], 1'b0);

    // Reset mid-word discards the partial lanes
    clear();
    push(8'h55); push(8'h66);
    run(3);
    rst = 1'b1; step();
    check("mr_valid", out_valid, 1'b0);
    check("mr_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    run(8);
    check("mr_beats", bd.size(), 1);
    check("mr_data",  bd[0], 32'h04030201);
    check("mr_keep",  bk[0], 4'hF);
    check("mr_last",  bl[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
